// File: rtl/rnn_layer_sequencer.sv
// Frame sequencer for the denoise RNN: walks six layer engines, strobes GRU state loads/clears.
// Optional per-frame cycle counter is built when SEQ_PERF_CNT_EN is defined.
module rnn_layer_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   state_clr,
  input  logic [5:0]             stage_valid,
  output logic [5:0]             stage_start,
  output logic                   ld_vad_state,
  output logic                   ld_noise_state,
  output logic                   ld_denoise_state,
  output logic                   gru_state_clr,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   error,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [31:0]            last_frame_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The counter reaches TIMEOUT_CYCLES-1 at the edge that closes the cycle where it holds TIMEOUT_CYCLES-2.
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 2);

  state_t        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ld_vad_d, ld_noise_d, ld_den_d, clr_d, ovr_d;
  logic          accept, frame_done, valid_k;

  assign valid_k = stage_valid[k_q];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    tcnt_d     = tcnt_q;
    ld_vad_d   = 1'b0;
    ld_noise_d = 1'b0;
    ld_den_d   = 1'b0;
    clr_d      = 1'b0;
    ovr_d      = 1'b0;
    accept     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      RUN: begin
        ovr_d  = start;
        tcnt_d = tcnt_q + 1'b1;
        if (valid_k) begin
          ld_vad_d   = (k_q == 3'd1);
          ld_noise_d = (k_q == 3'd3);
          ld_den_d   = (k_q == 3'd4);
          tcnt_d     = '0;
          if (k_q == 3'd5) begin
            state_d    = DONE;
            frame_done = 1'b1;
          end else begin
            k_d = k_q + 3'd1;
          end
        end else if (tcnt_q == T_LAST) begin
          state_d = ERR;
        end
      end
      default: begin
        clr_d = state_clr;
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          tcnt_d  = '0;
          accept  = 1'b1;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      tcnt_q           <= '0;
      ld_vad_state     <= 1'b0;
      ld_noise_state   <= 1'b0;
      ld_denoise_state <= 1'b0;
      gru_state_clr    <= 1'b0;
      overrun          <= 1'b0;
      frame_cnt        <= '0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      tcnt_q           <= tcnt_d;
      ld_vad_state     <= ld_vad_d;
      ld_noise_state   <= ld_noise_d;
      ld_denoise_state <= ld_den_d;
      gru_state_clr    <= clr_d;
      overrun          <= ovr_d;
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign stage_start = (state_q == RUN) ? (6'd1 << k_q) : 6'd0;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign error       = (state_q == ERR);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_inc;

  assign perf_inc = (perf_q == '1) ? perf_q : perf_q + 32'd1;

  // Snapshot includes the increment of the final RUN cycle, so it equals the frame's RUN cycle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q            <= '0;
      last_frame_cycles <= '0;
    end else begin
      if (accept) perf_q <= '0;
      else if (state_q == RUN) perf_q <= perf_inc;
      if (frame_done) last_frame_cycles <= perf_inc;
    end
  end
`else
  assign last_frame_cycles = 32'd0;
`endif

endmodule
